// File: rtl/fifo_pkg.sv
// Shared FIFO constants and the level-to-flag decode used by circ_fifo_param.
// Pure combinational helpers; no latency, no backpressure.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    // Wide enough for a level of 0..1024 and any AW+1-bit threshold.
    localparam int LVL_W = 11;

    typedef logic [LVL_W-1:0] lvl_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic thresh;
    } lvl_flags_t;

    function automatic lvl_flags_t decode_level(input lvl_t level, input lvl_t thresh,
                                                input lvl_t depth);
        lvl_flags_t f;
        f.full   = (level == depth);
        f.empty  = (level == '0);
        f.thresh = (level >= thresh);
        return f;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array: one write port, one registered read port (only the read register is reset).
// Latency: read data 1 cycle after re; no backpressure, caller guarantees legal addresses.
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register holds its value whenever no read is issued.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/circ_fifo_param.sv
// Circular-buffer FIFO with level flags, programmable threshold and sticky over/underflow.
// Latency: read data 1 cycle after accepted rd; backpressure: writes dropped when full without a read.
module circ_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] data_in,
    input  logic              flush,
    input  logic              clr_err,
    input  logic [AW:0]       thresh,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_threshold,
    output logic              fifo_overflow,
    output logic              fifo_underflow,
    output logic [AW:0]       fill_level
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          rd_valid_q, rd_valid_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          rd_acc;
    logic          wr_acc;
    logic          ram_we;
    logic          ram_re;
    lvl_flags_t    flags;

    always_comb begin
        flags  = decode_level(lvl_t'(count_q), lvl_t'(thresh), lvl_t'(DEPTH));
        rd_acc = rd && !flags.empty;
        // A read in the same cycle frees a slot, so a full FIFO still takes the write.
        wr_acc = wr && (!flags.full || rd_acc);
        ram_we = wr_acc && !flush;
        ram_re = rd_acc && !flush;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = ram_re;
        // Set terms are ORed after the clear so a coinciding event keeps the flag.
        ovf_d      = (ovf_q && !clr_err) || (wr && !wr_acc && !flush);
        udf_d      = (udf_q && !clr_err) || (rd && !rd_acc && !flush);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (ram_we) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (ram_re) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({ram_we, ram_re})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (data_out)
    );

    assign rd_valid       = rd_valid_q;
    assign fifo_full      = flags.full;
    assign fifo_empty     = flags.empty;
    assign fifo_threshold = flags.thresh;
    assign fifo_overflow  = ovf_q;
    assign fifo_underflow = udf_q;
    assign fill_level     = count_q;

endmodule

// File: tb/tb_circ_fifo_param.sv
// Directed bench for circ_fifo_param (DATA_W=8, DEPTH=16): one vector per clock,
// each carrying inputs and the hand-derived outputs expected just after that edge.
module tb_circ_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic       rd;
    logic [7:0] data_in;
    logic       flush;
    logic       clr_err;
    logic [4:0] thresh;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_threshold;
    logic       fifo_overflow;
    logic       fifo_underflow;
    logic [4:0] fill_level;

    int n_cmp = 0;
    int n_bad = 0;
    int vec_no = 0;

    typedef struct {
        logic       rst, wr, rd, flush, clr;
        logic [7:0] din;
        logic [4:0] thr;
        logic [7:0] e_dout;
        logic       e_vld, e_full, e_empty, e_thr, e_ovf, e_udf;
        logic [4:0] e_lvl;
    } vec_t;

    vec_t tbl[$];

    circ_fifo_param #(.DATA_W(8), .DEPTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr             (wr),
        .rd             (rd),
        .data_in        (data_in),
        .flush          (flush),
        .clr_err        (clr_err),
        .thresh         (thresh),
        .data_out       (data_out),
        .rd_valid       (rd_valid),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_threshold (fifo_threshold),
        .fifo_overflow  (fifo_overflow),
        .fifo_underflow (fifo_underflow),
        .fill_level     (fill_level)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic w, input logic rq, input logic f,
                                input logic c, input logic [7:0] d, input logic [4:0] t,
                                input logic [7:0] edo, input logic ev, input logic efu,
                                input logic eem, input logic eth, input logic eov,
                                input logic eun, input logic [4:0] el);
        vec_t v;
        v.rst = r; v.wr = w; v.rd = rq; v.flush = f; v.clr = c; v.din = d; v.thr = t;
        v.e_dout = edo; v.e_vld = ev; v.e_full = efu; v.e_empty = eem; v.e_thr = eth;
        v.e_ovf = eov; v.e_udf = eun; v.e_lvl = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", vec_no, name, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        rst = v.rst; wr = v.wr; rd = v.rd; flush = v.flush; clr_err = v.clr;
        data_in = v.din; thresh = v.thr;
        @(posedge clk);
        #1;
        chk("data_out",       32'(data_out),       32'(v.e_dout));
        chk("rd_valid",       32'(rd_valid),       32'(v.e_vld));
        chk("fifo_full",      32'(fifo_full),      32'(v.e_full));
        chk("fifo_empty",     32'(fifo_empty),     32'(v.e_empty));
        chk("fifo_threshold", 32'(fifo_threshold), 32'(v.e_thr));
        chk("fifo_overflow",  32'(fifo_overflow),  32'(v.e_ovf));
        chk("fifo_underflow", 32'(fifo_underflow), 32'(v.e_udf));
        chk("fill_level",     32'(fill_level),     32'(v.e_lvl));
        vec_no++;
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
        data_in = '0; thresh = 5'd12;

        // args: rst wr rd flush clr din thr | dout vld full empty thr ovf udf lvl
        tbl.push_back(mk(1,0,0,0,0,8'h00,5'd12, 8'h00,0,0,1,0,0,0,5'd0));
        for (int i = 1; i <= 16; i++)
            tbl.push_back(mk(0,1,0,0,0,8'(i),5'd12, 8'h00,0,(i == 16),0,(i >= 12),0,0,5'(i)));
        tbl.push_back(mk(0,1,0,0,0,8'h11,5'd12, 8'h00,0,1,0,1,1,0,5'd16));
        tbl.push_back(mk(0,0,0,0,0,8'h00,5'd17, 8'h00,0,1,0,0,1,0,5'd16));
        tbl.push_back(mk(0,0,0,0,0,8'h00,5'd16, 8'h00,0,1,0,1,1,0,5'd16));
        for (int i = 1; i <= 16; i++)
            tbl.push_back(mk(0,0,1,0,0,8'h00,5'd12, 8'(i),1,0,(i == 16),((16 - i) >= 12),1,0,5'(16 - i)));
        tbl.push_back(mk(0,0,0,0,0,8'h00,5'd12, 8'h10,0,0,1,0,1,0,5'd0));
        tbl.push_back(mk(0,0,0,0,0,8'h00,5'd0,  8'h10,0,0,1,1,1,0,5'd0));
        tbl.push_back(mk(0,0,1,0,0,8'h00,5'd12, 8'h10,0,0,1,0,1,1,5'd0));
        tbl.push_back(mk(0,0,0,0,0,8'h00,5'd12, 8'h10,0,0,1,0,1,1,5'd0));
        tbl.push_back(mk(0,0,0,0,1,8'h00,5'd12, 8'h10,0,0,1,0,0,0,5'd0));
        // Underflow set coinciding with clear keeps the flag.
        tbl.push_back(mk(0,0,1,0,1,8'h00,5'd12, 8'h10,0,0,1,0,0,1,5'd0));
        tbl.push_back(mk(0,0,0,0,1,8'h00,5'd12, 8'h10,0,0,1,0,0,0,5'd0));
        // rd+wr on empty: write only, underflow set.
        tbl.push_back(mk(0,1,1,0,0,8'h77,5'd12, 8'h10,0,0,0,0,0,1,5'd1));
        tbl.push_back(mk(0,0,1,0,0,8'h00,5'd12, 8'h77,1,0,1,0,0,1,5'd0));

        foreach (tbl[n]) run(tbl[n]);

        // Full with concurrent rd/wr across several pointer wraps.
        run(mk(1,0,0,0,0,8'h00,5'd12, 8'h00,0,0,1,0,0,0,5'd0));
        for (int k = 0; k < 16; k++)
            run(mk(0,1,0,0,0,8'(k),5'd12, 8'h00,0,(k == 15),0,(k >= 11),0,0,5'(k + 1)));
        for (int k = 0; k < 40; k++)
            run(mk(0,1,1,0,0,8'(16 + k),5'd12, 8'(k),1,1,0,1,0,0,5'd16));

        // Flush: drops stored words and the flush-cycle write, keeps data_out and sticky flags.
        run(mk(1,0,0,0,0,8'h00,5'd12, 8'h00,0,0,1,0,0,0,5'd0));
        run(mk(0,0,1,0,0,8'h00,5'd12, 8'h00,0,0,1,0,0,1,5'd0));
        for (int k = 0; k < 5; k++)
            run(mk(0,1,0,0,0,8'(8'hA0 + k),5'd12, 8'h00,0,0,0,0,0,1,5'(k + 1)));
        run(mk(0,0,1,0,0,8'h00,5'd12, 8'hA0,1,0,0,0,0,1,5'd4));
        run(mk(0,1,1,1,0,8'hEE,5'd12, 8'hA0,0,0,1,0,0,1,5'd0));
        run(mk(0,1,0,0,0,8'h55,5'd12, 8'hA0,0,0,0,0,0,1,5'd1));
        run(mk(0,0,1,0,0,8'h00,5'd12, 8'h55,1,0,1,0,0,1,5'd0));

        // Reset during a read: no rd_valid afterwards, all entries gone.
        run(mk(1,0,0,0,0,8'h00,5'd12, 8'h00,0,0,1,0,0,0,5'd0));
        for (int k = 0; k < 7; k++)
            run(mk(0,1,0,0,0,8'(8'h30 + k),5'd12, 8'h00,0,0,0,0,0,0,5'(k + 1)));
        run(mk(1,0,1,0,0,8'h00,5'd12, 8'h00,0,0,1,0,0,0,5'd0));
        run(mk(0,0,0,0,0,8'h00,5'd12, 8'h00,0,0,1,0,0,0,5'd0));
        run(mk(0,0,1,0,0,8'h00,5'd12, 8'h00,0,0,1,0,0,1,5'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
